// File: rtl/rgbw_fade_pwm.sv
// Multi-channel PWM with per-channel targets; levels move toward targets at period boundaries.
// Build macro RGBW_FADE_PWM_FADE_EN selects rate-limited fading instead of direct level loads.
module rgbw_fade_pwm #(
  parameter int N_CH      = 4,
  parameter int PWM_W     = 8,
  parameter int PRESC_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_ch,
  input  logic [PWM_W-1:0]  wr_level,
  input  logic [3:0]        wr_rate,
  output logic [N_CH-1:0]   pwm_out,
  output logic [N_CH-1:0]   fade_busy
);

  localparam int PS_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESC_DIV - 1);
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);

  // Handshake: a write transfers on any cycle with wr_valid && wr_ready;
  // wr_ready is simply "out of reset", so the writer never stalls.
  logic wr_fire;
  assign wr_ready = rst_n;
  assign wr_fire  = wr_valid & wr_ready;

  logic [PS_W-1:0]  presc;
  logic [PWM_W-1:0] cnt;
  logic             tick;
  logic             bnd;

  logic [PWM_W-1:0] target   [N_CH];
  logic [PWM_W-1:0] level    [N_CH];
  logic [PWM_W-1:0] level_nx [N_CH];
  logic [PWM_W-1:0] duty     [N_CH];
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  pwm_q;

  assign tick = en && (presc == PS_LAST);
  assign bnd  = tick && (cnt == CNT_LAST);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = wr_fire && (wr_ch == 3'(i));
    end
  end

`ifdef RGBW_FADE_PWM_FADE_EN
  logic [3:0] rate [N_CH];
  logic [3:0] rcnt [N_CH];

  // Boundary step reads the pre-write target/rate, so a colliding write lands next period.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      level_nx[i] = level[i];
      if (bnd && (rcnt[i] == rate[i])) begin
        if (level[i] < target[i])
          level_nx[i] = level[i] + 1'b1;
        else if (level[i] > target[i])
          level_nx[i] = level[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!rst_n) begin
        rate[i] <= '0;
        rcnt[i] <= '0;
      end else if (wr_hit[i]) begin
        rate[i] <= wr_rate;
        rcnt[i] <= '0;
      end else if (bnd) begin
        rcnt[i] <= (rcnt[i] == rate[i]) ? 4'd0 : rcnt[i] + 1'b1;
      end
    end
  end
`else
  logic unused_rate;
  assign unused_rate = ^wr_rate;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      level_nx[i] = bnd ? target[i] : level[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
      pwm_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        target[i] <= '0;
        level[i]  <= '0;
        duty[i]   <= '0;
      end
    end else begin
      if (!en) begin
        presc <= '0;
        cnt   <= '0;
      end else if (tick) begin
        presc <= '0;
        cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      for (int i = 0; i < N_CH; i++) begin
        level[i] <= level_nx[i];
        if (bnd)
          duty[i] <= level_nx[i];
        if (wr_hit[i])
          target[i] <= wr_level;
        // Full-scale duty exceeds the largest cnt value, giving a constant-high output.
        pwm_q[i] <= en && (cnt < duty[i]);
      end
    end
  end

  assign pwm_out = pwm_q;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fade_busy[i] = rst_n && (level[i] != target[i]);
    end
  end

endmodule
